tpu_mmio_sequencer: RTL and testbench

Sequences host MMIO traffic onto the single-port tpuv1 register interface inside the CCI-P AFU. It queues MMIO writes in a small FIFO and holds one outstanding MMIO read. It also enforces read-after-write ordering and returns read data tagged with the host TID. It sits between the AFU's CCI-P Rx/Tx decode and the accelerator.

---
 rtl/tpu_mmio_sequencer_if.sv | 40 ++++
 rtl/tpu_mmio_sequencer.sv | 165 ++++++++++++++++
 tb/tb_tpu_mmio_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_mmio_sequencer_if.sv
// Host MMIO and accelerator register-port signals for tpu_mmio_sequencer.
// The master modport is the environment: the host decode and the accelerator.
interface tpu_mmio_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TID_W  = 9
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [TID_W-1:0]  rd_tid;
  logic              acc_wr_en;
  logic              acc_rd_en;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_rd_ack;
  logic              rsp_valid;
  logic [TID_W-1:0]  rsp_tid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              wr_drop;
  logic              rd_drop;
  logic              wfifo_full;
  logic              busy;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_tid, acc_rdata, acc_rd_ack,
    input  acc_wr_en, acc_rd_en, acc_addr, acc_wdata, rsp_valid, rsp_tid, rsp_data,
    input  rsp_timeout, wr_drop, rd_drop, wfifo_full, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_tid, acc_rdata, acc_rd_ack,
    output acc_wr_en, acc_rd_en, acc_addr, acc_wdata, rsp_valid, rsp_tid, rsp_data,
    output rsp_timeout, wr_drop, rd_drop, wfifo_full, busy
  );
endinterface

// File: rtl/tpu_mmio_sequencer.sv
// Orders host MMIO writes (FIFO) and a single pending read onto the tpuv1 register port.
// Optional read timeout is enabled by defining TPU_SEQ_TIMEOUT_EN.
module tpu_mmio_sequencer #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TID_W       = 9,
  parameter int unsigned WFIFO_DEPTH = 4
`ifdef TPU_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned RD_TIMEOUT  = 255
`endif
) (
  input logic                clk,
  input logic                rst_n,
  tpu_mmio_sequencer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StWrite     = 3'd1;
  localparam logic [2:0] StReadIssue = 3'd2;
  localparam logic [2:0] StReadWait  = 3'd3;
  localparam logic [2:0] StResp      = 3'd4;

  logic [2:0]        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_count, w_count_nxt;
  logic              w_full, w_push, w_pop, w_wr_drop, w_rd_accept, w_rd_drop;
  logic              r_rd_pending;
  logic [ADDR_W-1:0] r_rd_addr, r_addr_hold, w_acc_addr;
  logic [TID_W-1:0]  r_rd_tid;
  logic [DATA_W-1:0] r_wdata_hold, w_acc_wdata, r_rsp_data;
  logic              r_wr_drop, r_rd_drop;
  logic              w_ack, w_timeout_hit;

  assign w_full      = (r_count == (PTR_W+1)'(WFIFO_DEPTH));
  assign w_pop       = (r_state == StWrite);
  assign w_push      = bus.wr_valid && (!w_full || w_pop);
  assign w_wr_drop   = bus.wr_valid && w_full && !w_pop;
  // The pending read retires in StResp, so a read arriving then may take its place.
  assign w_rd_accept = bus.rd_valid && (!r_rd_pending || (r_state == StResp));
  assign w_rd_drop   = bus.rd_valid && !w_rd_accept;
  assign w_count_nxt = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
  assign w_ack       = (r_state == StReadWait) && bus.acc_rd_ack;

`ifdef TPU_SEQ_TIMEOUT_EN
  localparam int unsigned TmrW = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;

  logic [TmrW-1:0] r_timer;
  logic            r_timeout;

  assign w_timeout_hit = (r_state == StReadWait) && !bus.acc_rd_ack &&
                         (r_timer == TmrW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timer <= (r_state == StReadWait) ? r_timer + TmrW'(1) : '0;
      if (w_ack) begin
        r_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.rsp_timeout = r_timeout && (r_state == StResp);
`else
  assign w_timeout_hit   = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_state_nxt = StWrite;
        end else if (r_rd_pending) begin
          w_state_nxt = StReadIssue;
        end
      end
      StWrite:     w_state_nxt = (w_count_nxt != '0) ? StWrite : StIdle;
      StReadIssue: w_state_nxt = StReadWait;
      StReadWait:  if (w_ack || w_timeout_hit) w_state_nxt = StResp;
      StResp:      w_state_nxt = StIdle;
      default:     w_state_nxt = StIdle;
    endcase
  end

  // Address/data lines show the active transfer and otherwise hold the last one.
  always_comb begin
    w_acc_addr  = r_addr_hold;
    w_acc_wdata = r_wdata_hold;
    if (r_state == StWrite) begin
      w_acc_addr  = r_fifo_addr[r_rptr];
      w_acc_wdata = r_fifo_data[r_rptr];
    end else if (r_state == StReadIssue) begin
      w_acc_addr  = r_rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= bus.wr_addr;
      r_fifo_data[r_wptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_rd_pending <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_tid     <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
      r_rsp_data   <= '0;
      r_wr_drop    <= 1'b0;
      r_rd_drop    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_addr_hold  <= w_acc_addr;
      r_wdata_hold <= w_acc_wdata;
      r_wr_drop    <= w_wr_drop;
      r_rd_drop    <= w_rd_drop;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_rd_accept) begin
        r_rd_pending <= 1'b1;
        r_rd_addr    <= bus.rd_addr;
        r_rd_tid     <= bus.rd_tid;
      end else if (r_state == StResp) begin
        r_rd_pending <= 1'b0;
      end
      if (w_ack) begin
        r_rsp_data <= bus.acc_rdata;
      end else if (w_timeout_hit) begin
        r_rsp_data <= '1;
      end
    end
  end

  assign bus.acc_wr_en  = (r_state == StWrite);
  assign bus.acc_rd_en  = (r_state == StReadIssue);
  assign bus.acc_addr   = w_acc_addr;
  assign bus.acc_wdata  = w_acc_wdata;
  assign bus.rsp_valid  = (r_state == StResp);
  assign bus.rsp_tid    = r_rd_tid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.wr_drop    = r_wr_drop;
  assign bus.rd_drop    = r_rd_drop;
  assign bus.wfifo_full = w_full;
  assign bus.busy       = (r_state != StIdle) || (r_count != '0) || r_rd_pending;

endmodule

// File: tb/tb_tpu_mmio_sequencer.sv
// Directed self-checking bench for tpu_mmio_sequencer; cycle c is the interval after edge c.
module tb_tpu_mmio_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_rsp = 0;
  int   n_wr_en = 0;
  int   n_wr_drop = 0;
  int   base_rsp, base_wr_en, base_wr_drop, base_log;
  logic [15:0] wlog_addr[$];
  logic [63:0] wlog_data[$];

  tpu_mmio_sequencer_if bus ();

  tpu_mmio_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.acc_wr_en) begin
      wlog_addr.push_back(bus.acc_addr);
      wlog_data.push_back(bus.acc_wdata);
      n_wr_en++;
    end
    if (bus.rsp_valid) n_rsp++;
    if (bus.wr_drop) n_wr_drop++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_valid   = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_tid     = '0;
    bus.acc_rdata  = '0;
    bus.acc_rd_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 64'(bus.acc_wr_en), 64'd0);
    check({tag, "_rd_en"}, 64'(bus.acc_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(bus.acc_addr), 64'd0);
    check({tag, "_wdata"}, bus.acc_wdata, 64'd0);
    check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_timeout, bus.wr_drop, bus.rd_drop,
                          bus.wfifo_full, bus.busy}, 64'd0);
    check({tag, "_tid"}, 64'(bus.rsp_tid), 64'd0);
    check({tag, "_rdata"}, bus.rsp_data, 64'd0);
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single write
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'h0300;
    bus.wr_data  = 64'h1122334455667788;
    tick();
    idle_inputs();
    check("wr1_c1_en", 64'(bus.acc_wr_en), 64'd0);
    tick();
    check("wr1_c2_en", 64'(bus.acc_wr_en), 64'd1);
    check("wr1_c2_addr", 64'(bus.acc_addr), 64'h0300);
    check("wr1_c2_data", bus.acc_wdata, 64'h1122334455667788);
    tick();
    check("wr1_c3_en", 64'(bus.acc_wr_en), 64'd0);
    check("wr1_c3_busy", 64'(bus.busy), 64'd0);
    check("wr1_c3_hold", 64'(bus.acc_addr), 64'h0300);

    // Read after three writes
    base_log = wlog_addr.size();
    for (int c = 0; c <= 10; c++) begin
      bus.wr_valid   = (c <= 2);
      bus.wr_addr    = 16'(16 + 8 * c);
      bus.wr_data    = 64'(c + 1);
      bus.rd_valid   = (c == 3);
      bus.rd_addr    = 16'h0308;
      bus.rd_tid     = 9'h005;
      bus.acc_rd_ack = (c == 8);
      bus.acc_rdata  = 64'hABCD;
      check($sformatf("raw_c%0d_wr_en", c), 64'(bus.acc_wr_en), 64'(c >= 2 && c <= 4));
      check($sformatf("raw_c%0d_rd_en", c), 64'(bus.acc_rd_en), 64'(c == 6));
      check($sformatf("raw_c%0d_rsp", c), 64'(bus.rsp_valid), 64'(c == 9));
      if (c == 6) check("raw_rd_addr", 64'(bus.acc_addr), 64'h0308);
      if (c == 9) begin
        check("raw_rsp_tid", 64'(bus.rsp_tid), 64'h005);
        check("raw_rsp_data", bus.rsp_data, 64'hABCD);
        check("raw_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
      end
      tick();
    end
    idle_inputs();
    check("raw_nwrites", 64'(wlog_addr.size() - base_log), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (base_log + i < wlog_addr.size()) begin
        check($sformatf("raw_log%0d_addr", i), 64'(wlog_addr[base_log + i]), 64'(16 + 8 * i));
        check($sformatf("raw_log%0d_data", i), wlog_data[base_log + i], 64'(i + 1));
      end
    end

    // Overflow while a read stalls
    base_log     = wlog_addr.size();
    base_wr_drop = n_wr_drop;
    for (int c = 0; c <= 18; c++) begin
      bus.rd_valid   = (c == 0);
      bus.rd_addr    = 16'h0040;
      bus.rd_tid     = 9'h001;
      bus.wr_valid   = (c >= 3 && c <= 8);
      bus.wr_addr    = 16'(256 + 8 * (c - 3));
      bus.wr_data    = 64'(80 + c - 3);
      bus.acc_rd_ack = (c == 10);
      bus.acc_rdata  = 64'h77;
      check($sformatf("ovf_c%0d_full", c), 64'(bus.wfifo_full), 64'(c >= 7 && c <= 13));
      check($sformatf("ovf_c%0d_drop", c), 64'(bus.wr_drop), 64'(c == 8 || c == 9));
      check($sformatf("ovf_c%0d_wr_en", c), 64'(bus.acc_wr_en), 64'(c >= 13 && c <= 16));
      check($sformatf("ovf_c%0d_rsp", c), 64'(bus.rsp_valid), 64'(c == 11));
      if (c == 11) begin
        check("ovf_rsp_tid", 64'(bus.rsp_tid), 64'h001);
        check("ovf_rsp_data", bus.rsp_data, 64'h77);
      end
      if (c >= 17) check($sformatf("ovf_c%0d_busy", c), 64'(bus.busy), 64'd0);
      tick();
    end
    idle_inputs();
    check("ovf_ndrop", 64'(n_wr_drop - base_wr_drop), 64'd2);
    check("ovf_nwrites", 64'(wlog_addr.size() - base_log), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (base_log + i < wlog_addr.size()) begin
        check($sformatf("ovf_log%0d_addr", i), 64'(wlog_addr[base_log + i]), 64'(256 + 8 * i));
        check($sformatf("ovf_log%0d_data", i), wlog_data[base_log + i], 64'(80 + i));
      end
    end

    // Double read
    base_rsp = n_rsp;
    for (int c = 0; c <= 9; c++) begin
      bus.rd_valid   = (c <= 1);
      bus.rd_addr    = (c == 0) ? 16'h0050 : 16'h0058;
      bus.rd_tid     = (c == 0) ? 9'h003 : 9'h007;
      bus.acc_rd_ack = (c == 4);
      bus.acc_rdata  = 64'h1234;
      check($sformatf("dbl_c%0d_rd_drop", c), 64'(bus.rd_drop), 64'(c == 2));
      check($sformatf("dbl_c%0d_rd_en", c), 64'(bus.acc_rd_en), 64'(c == 2));
      if (c == 2) check("dbl_rd_addr", 64'(bus.acc_addr), 64'h0050);
      if (c == 5) begin
        check("dbl_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("dbl_rsp_tid", 64'(bus.rsp_tid), 64'h003);
        check("dbl_rsp_data", bus.rsp_data, 64'h1234);
      end
      tick();
    end
    idle_inputs();
    check("dbl_nrsp", 64'(n_rsp - base_rsp), 64'd1);

    // Reset during READ_WAIT with two queued writes
    for (int c = 0; c <= 5; c++) begin
      bus.rd_valid = (c == 0);
      bus.rd_addr  = 16'h0070;
      bus.rd_tid   = 9'h009;
      bus.wr_valid = (c == 3 || c == 4);
      bus.wr_addr  = 16'h0A00;
      bus.wr_data  = 64'hDEAD;
      if (c == 5) check("rst_pre_busy", 64'(bus.busy), 64'd1);
      if (c < 5) tick();
    end
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    base_rsp   = n_rsp;
    base_wr_en = n_wr_en;
    for (int c = 0; c <= 5; c++) begin
      bus.acc_rd_ack = (c == 2);
      bus.acc_rdata  = 64'h5555;
      tick();
    end
    idle_inputs();
    check("rst_post_nrsp", 64'(n_rsp - base_rsp), 64'd0);
    check("rst_post_nwr", 64'(n_wr_en - base_wr_en), 64'd0);
    check("rst_post_busy", 64'(bus.busy), 64'd0);
    for (int c = 0; c <= 5; c++) begin
      bus.rd_valid   = (c == 0);
      bus.rd_addr    = 16'h0060;
      bus.rd_tid     = 9'h011;
      bus.acc_rd_ack = (c == 3);
      bus.acc_rdata  = 64'hFEED;
      check($sformatf("fresh_c%0d_rd_en", c), 64'(bus.acc_rd_en), 64'(c == 2));
      check($sformatf("fresh_c%0d_rsp", c), 64'(bus.rsp_valid), 64'(c == 4));
      if (c == 4) begin
        check("fresh_rsp_tid", 64'(bus.rsp_tid), 64'h011);
        check("fresh_rsp_data", bus.rsp_data, 64'hFEED);
      end
      tick();
    end
    idle_inputs();

`ifdef TPU_SEQ_TIMEOUT_EN
    begin
      int first_rsp;
      first_rsp = -1;
      base_rsp  = n_rsp;
      for (int c = 0; c <= 300; c++) begin
        bus.rd_valid   = (c == 0);
        bus.rd_addr    = 16'h0080;
        bus.rd_tid     = 9'h0AA;
        bus.acc_rd_ack = (c == 270);
        bus.acc_rdata  = 64'h0BAD;
        if (bus.rsp_valid && first_rsp < 0) begin
          first_rsp = c;
          check("tmo_rsp_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
          check("tmo_rsp_flag", 64'(bus.rsp_timeout), 64'd1);
          check("tmo_rsp_tid", 64'(bus.rsp_tid), 64'h0AA);
        end
        tick();
      end
      idle_inputs();
      // READ_WAIT is entered in cycle 3
      check("tmo_rsp_cycle", 64'(first_rsp), 64'(3 + 255));
      check("tmo_nrsp", 64'(n_rsp - base_rsp), 64'd1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
